// File: rtl/prog_loader.sv
// Framed byte-stream loader for the core's instruction memory. The core is held
// in reset until a complete frame with a matching checksum has been written.
module prog_loader #(
    parameter int unsigned M = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [M+1:0] mem_addr,
    output logic [7:0]   mem_data,
    output logic         mem_we,
    output logic         cpu_rst_n,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned CW = M + 3;
    localparam logic [31:0] MAX_WORDS = 32'd1 << M;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [M:0]    len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic          we_q, we_d;
    logic [M+1:0]  addr_q, addr_d;
    logic [7:0]    data_q, data_d;

    logic          xfer;
    logic [15:0]   len_word;
    logic          len_ok;
    logic [CW-1:0] last_idx;

    // Status is decoded straight from the state register, so every flag takes
    // its reset value the moment rst falls.
    assign in_ready  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign busy      = in_ready;
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);
    assign cpu_rst_n = (state_q == ST_DONE);

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;

    assign xfer      = in_valid & in_ready;
    assign len_word  = {len_hi_q, in_data};
    assign len_ok    = (len_word != 16'd0) && ({16'd0, len_word} <= MAX_WORDS);
    assign last_idx  = CW'({len_q, 2'b00}) - CW'(1);

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    if (len_ok) begin
                        len_d   = len_word[M:0];
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[M+1:0];
                    data_d = in_data;
                    sum_d  = sum_q + in_data;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == last_idx) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    state_d = (in_data == sum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program loader for the 32-bit core. It receives a framed byte stream over a valid/ready handshake and writes it byte-by-byte into the core's instruction memory, which is organised as 4·2**M bytes and fetched big-endian. It holds the core in reset until a complete frame with a correct checksum has been written. It then releases the core's active-low reset so execution starts at pc = 0.

## Interface
- M, 10, log2 of instruction-memory depth in 32-bit words; byte address width is M+2.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse that begins a new load; ignored while busy.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs on a rising clk edge where in_valid & in_ready.
- mem_addr  out  M+2  instruction-memory byte address.
- mem_data  out  8  byte to write.
- mem_we  out  1  write strobe, one cycle per byte.
- cpu_rst_n  out  1  drives the core's rst; low = core held in reset.
- busy  out  1  a load is in progress.
- done  out  1  last load completed successfully (sticky until next start or reset).
- error  out  1  last load failed (sticky until next start or reset).

## Operation
- Frame format, in stream order:
  - LEN_HI, LEN_LO: L = big-endian 16-bit word count.
  - 4·L payload bytes.
  - CHK = (sum of payload bytes) mod 256.
- Payload byte k is written to byte address k. The first byte of each word therefore lands in the word's MSB under the core's big-endian fetch.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- IDLE/DONE/ERR + start → LEN_HI. On this transition:
  - cpu_rst_n←0, done←0, error←0, busy←1.
  - byte counter←0, checksum accumulator←0.
- LEN_HI --accept--> LEN_LO.
- LEN_LO --accept--> DATA if 1 ≤ L ≤ 2**M, else ERR.
- DATA: each accepted byte adds to the 8-bit accumulator (wraps mod 256) and issues one write. After byte index 4L−1 → CHK.
- CHK --accept--> DONE if the byte equals the accumulator, else ERR.
- DONE: cpu_rst_n←1, done←1, busy←0.
- ERR: error←1, busy←0, cpu_rst_n stays 0. Memory contents already written are left in place.
- in_ready = 1 exactly in LEN_HI, LEN_LO, DATA, CHK. It depends on state only, never on in_valid.
- start while busy: ignored, no state change.
- start in the same cycle as a transfer is impossible, since in_ready=0 whenever start is honoured.
- Byte counter is M+3 bits wide, so 4·2**M is representable. mem_addr is the low M+2 bits.

## Timing
- Reset values, applied immediately when rst falls and held while rst is low:
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_data=0.
  - cpu_rst_n=0, busy=0, done=0, error=0.
- Reset mid-load aborts at once. No further writes occur; the core stays in reset.
- Throughput: one byte per cycle when in_valid is held high. Gaps with in_valid=0 stall without state change.
- Write timing: mem_we, mem_addr and mem_data are registered. They are valid the cycle after the byte is accepted, and mem_we is high for exactly that one cycle.
- In the cycle after the CHK byte is accepted:
  - cpu_rst_n=1, done=1, busy=0.
  - The final payload write (issued the cycle before) has already completed, so the core never fetches unwritten memory.
- Minimum load length: 4L+3 transfer cycles after start, plus 1 cycle for the start→LEN_HI transition.
- busy rises the cycle after start is sampled.

## Test plan
- Reset: assert rst mid-simulation → all outputs take their reset values asynchronously, before the next clk edge.
- Good frame: start; stream 00 01, AA BB CC DD, CHK 0E (0xAA+0xBB+0xCC+0xDD = 0x30E).
  - Required: writes (0,AA), (1,BB), (2,CC), (3,DD) on consecutive cycles.
  - Required: the cycle after CHK, cpu_rst_n=1 and done=1.
- Bad checksum: same frame with CHK 0F → error=1, done=0, cpu_rst_n=0, in_ready=0.
- Bad length: L=0000 → ERR after 2 bytes with no mem_we. Separately, L=0401 with M=10 → ERR with no writes.
- Full memory with random in_valid gaps: L=0400, payload byte k = k mod 256, correct CHK.
  - Required: 4096 writes, last at addr 0xFFF, done=1.
  - Required: no transfer and no write occurs in any cycle where in_valid=0.
- Abort and restart:
  - rst low after 5 payload bytes → no further writes.
  - New load after reset completes correctly.
  - start pulsed mid-DATA is ignored; the frame still completes with done=1.
